// File: rtl/icache_nway.sv
`default_nettype none
// ============================================================================
// Module      : icache_nway
// Description : N-way set-associative, read-only instruction cache sitting
//               between the IF stage and the AXI bridge read port. Burst
//               refill with critical-word early restart, first-invalid /
//               per-set round-robin replacement, index and full invalidate.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk_g,
  input  logic                    reset,
  input  logic                    valid,
  input  logic                    uncache,
  input  logic [31:0]             addr,
  output logic                    addr_ok,
  output logic                    data_ok,
  output logic [31:0]             rdata,
  input  logic                    inv_valid,
  input  logic                    inv_all,
  input  logic [$clog2(SETS)-1:0] inv_index,
  output logic                    inv_ok,
  output logic                    rd_req,
  output logic [2:0]              rd_type,
  output logic [31:0]             rd_addr,
  input  logic                    rd_rdy,
  input  logic                    ret_valid,
  input  logic                    ret_last,
  input  logic [31:0]             ret_data
);

  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam int WRD_W = OFF_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] c_RD_WORD = 3'b010;
  localparam logic [2:0] c_RD_LINE = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_REFILL = 3'd3,
    S_INVALL = 3'd4
  } state_t;

  state_t r_state, w_state_nx;

  // Storage arrays: valid bits and replacement pointers are reset, tag/data are not
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAY_W-1:0] r_rr    [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [31:0]      r_data  [SETS][WAYS][LINE_WORDS];
  logic [31:0]      r_lbuf  [LINE_WORDS];

  // Request buffer and miss bookkeeping
  logic [31:0]      r_rb_addr;
  logic             r_rb_unc;
  logic [WAY_W-1:0] r_victim;
  logic [WRD_W-1:0] r_cnt;
  logic             r_crit_done;
  logic [IDX_W-1:0] r_sweep;

  logic [IDX_W-1:0] w_rb_idx;
  logic [TAG_W-1:0] w_rb_tag;
  logic [WRD_W-1:0] w_rb_word;
  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_inv_found;
  logic [WAY_W-1:0] w_vic;
  logic             w_crit;

  assign w_rb_idx  = r_rb_addr[OFF_W +: IDX_W];
  assign w_rb_tag  = r_rb_addr[31 -: TAG_W];
  assign w_rb_word = r_rb_addr[OFF_W-1:2];

  // Critical word is the first beat for uncached reads, else the requested offset
  assign w_crit = !r_crit_done && (r_rb_unc || (r_cnt == w_rb_word));

  // Tag compare; scanning downward lets the lowest hitting way win
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_rb_idx][w] && (r_tag[w_rb_idx][w] == w_rb_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    if (r_rb_unc) w_hit = 1'b0;
  end

  // Victim choice: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    w_inv_found = 1'b0;
    w_vic       = r_rr[w_rb_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_rb_idx][w]) begin
        w_inv_found = 1'b1;
        w_vic       = WAY_W'(w);
      end
    end
  end

  // State register
  always_ff @(posedge clk_g or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state and output decode
  always_comb begin
    w_state_nx = r_state;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    rdata      = 32'h0;
    inv_ok     = 1'b0;
    rd_req     = 1'b0;
    rd_type    = c_RD_LINE;
    rd_addr    = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (inv_all) begin
          w_state_nx = S_INVALL;
        end else if (inv_valid) begin
          inv_ok = 1'b1;
        end else if (valid) begin
          addr_ok    = 1'b1;
          w_state_nx = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          data_ok    = 1'b1;
          rdata      = r_data[w_rb_idx][w_hit_way][w_rb_word];
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_MISS;
        end
      end
      S_MISS: begin
        rd_req  = 1'b1;
        rd_type = r_rb_unc ? c_RD_WORD : c_RD_LINE;
        rd_addr = r_rb_unc ? r_rb_addr : {w_rb_tag, w_rb_idx, {OFF_W{1'b0}}};
        if (rd_rdy) w_state_nx = S_REFILL;
      end
      S_REFILL: begin
        if (ret_valid) begin
          if (w_crit) begin
            data_ok = 1'b1;
            rdata   = ret_data;
          end
          if (ret_last) w_state_nx = S_IDLE;
        end
      end
      S_INVALL: begin
        if (r_sweep == IDX_W'(SETS - 1)) begin
          inv_ok     = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Control state: request buffer, valid bits, pointers, counters
  always_ff @(posedge clk_g or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
      r_rb_addr   <= 32'h0;
      r_rb_unc    <= 1'b0;
      r_victim    <= '0;
      r_cnt       <= '0;
      r_crit_done <= 1'b0;
      r_sweep     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inv_all) begin
            r_sweep <= '0;
          end else if (inv_valid) begin
            r_valid[inv_index] <= '0;
          end else if (valid) begin
            r_rb_addr <= addr;
            r_rb_unc  <= uncache;
          end
        end
        S_LOOKUP: begin
          if (!w_hit) begin
            r_victim <= w_vic;
            // Pointer only moves when it actually supplied the victim
            if (!r_rb_unc && !w_inv_found) begin
              r_rr[w_rb_idx] <= (r_rr[w_rb_idx] == WAY_W'(WAYS - 1)) ?
                                '0 : r_rr[w_rb_idx] + 1'b1;
            end
          end
        end
        S_MISS: begin
          if (rd_rdy) begin
            r_cnt       <= '0;
            r_crit_done <= 1'b0;
          end
        end
        S_REFILL: begin
          if (ret_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_crit) r_crit_done <= 1'b1;
            if (ret_last && !r_rb_unc) r_valid[w_rb_idx][r_victim] <= 1'b1;
          end
        end
        S_INVALL: begin
          r_valid[r_sweep] <= '0;
          r_sweep          <= r_sweep + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line buffer capture and line/tag commit on the final beat
  always_ff @(posedge clk_g) begin
    if ((r_state == S_REFILL) && ret_valid) begin
      r_lbuf[r_cnt] <= ret_data;
      if (ret_last && !r_rb_unc) begin
        r_tag[w_rb_idx][r_victim] <= w_rb_tag;
        for (int i = 0; i < LINE_WORDS; i++) begin
          r_data[w_rb_idx][r_victim][i] <= (WRD_W'(i) == r_cnt) ? ret_data : r_lbuf[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_nway
// Description : Directed self-checking bench for icache_nway (2 ways,
//               16 sets, 4-word lines) with an rdata scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_nway;

  logic        clk_g = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        uncache = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        addr_ok, data_ok, inv_ok, rd_req;
  logic [31:0] rdata, rd_addr;
  logic [2:0]  rd_type;
  logic        inv_valid = 1'b0;
  logic        inv_all = 1'b0;
  logic [3:0]  inv_index = 4'h0;
  logic        rd_rdy = 1'b0;
  logic        ret_valid = 1'b0;
  logic        ret_last = 1'b0;
  logic [31:0] ret_data = 32'h0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] beat_mem[8];

  icache_nway #(.WAYS(2), .SETS(16), .LINE_WORDS(4)) dut (
    .clk_g(clk_g), .reset(reset), .valid(valid), .uncache(uncache), .addr(addr),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .inv_valid(inv_valid), .inv_all(inv_all), .inv_index(inv_index), .inv_ok(inv_ok),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
  );

  always #5 clk_g = ~clk_g;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [31:0] e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, rdata, e);
    end
  endtask

  task automatic set_line(input logic [31:0] base);
    for (int i = 0; i < 8; i++) beat_mem[i] = base + 32'(i);
  endtask

  // One fetch from IDLE; on a miss the bridge side is modelled here
  task automatic do_fetch(input logic [31:0] a, input logic unc, input bit exp_hit,
                          input logic [31:0] exp_data, input int nbeats, input string tag);
    int          seen;
    int          k;
    logic [31:0] exp_ra;
    logic [2:0]  exp_ty;
    seen   = 0;
    exp_ra = unc ? a : {a[31:4], 4'h0};
    exp_ty = unc ? 3'b010 : 3'b100;
    exp_q.push_back(exp_data);
    valid = 1'b1; addr = a; uncache = unc;
    #1;
    chk({tag, "_addr_ok"}, 32'(addr_ok), 32'd1);
    @(negedge clk_g);
    valid = 1'b0; addr = 32'h0; uncache = 1'b0;
    #1;
    chk({tag, "_lookup_addr_ok"}, 32'(addr_ok), 32'd0);
    if (exp_hit) begin
      chk({tag, "_hit"}, 32'(data_ok), 32'd1);
      if (data_ok) sb_pop(tag);
    end else begin
      chk({tag, "_lookup_miss"}, 32'(data_ok), 32'd0);
      @(negedge clk_g);
      k = 0;
      while (!rd_req && k < 8) begin
        @(negedge clk_g);
        k++;
      end
      chk({tag, "_rd_req"}, 32'(rd_req), 32'd1);
      chk({tag, "_rd_addr"}, rd_addr, exp_ra);
      chk({tag, "_rd_type"}, 32'(rd_type), 32'(exp_ty));
      @(negedge clk_g);
      chk({tag, "_rd_hold"}, {rd_req, rd_type, rd_addr[27:0]}, {1'b1, exp_ty, exp_ra[27:0]});
      rd_rdy = 1'b1;
      @(negedge clk_g);
      rd_rdy = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
        ret_valid = 1'b1;
        ret_data  = beat_mem[b];
        ret_last  = (b == nbeats - 1);
        #1;
        if (data_ok) begin
          seen++;
          sb_pop(tag);
        end
        @(negedge clk_g);
      end
      ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
      chk({tag, "_crit_once"}, 32'(seen), 32'd1);
    end
    @(negedge clk_g);
  endtask

  initial begin
    int hit_k;
    int aok;

    // Reset state
    repeat (2) @(negedge clk_g);
    #1;
    chk("reset_outputs", {28'h0, data_ok, rd_req, inv_ok, addr_ok}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    @(negedge clk_g);
    reset = 1'b0;
    @(negedge clk_g);

    // Cold miss with critical-word restart, then hit on the same line
    set_line(32'hA0);
    do_fetch(32'h1fc0_0008, 1'b0, 1'b0, 32'hA2, 4, "cold");
    do_fetch(32'h1fc0_000c, 1'b0, 1'b1, 32'hA3, 0, "rehit");

    // Uncached single-word reads never allocate
    beat_mem[0] = 32'h1234_5678;
    do_fetch(32'hbfc0_0004, 1'b1, 1'b0, 32'h1234_5678, 1, "unc1");
    do_fetch(32'hbfc0_0004, 1'b1, 1'b0, 32'h1234_5678, 1, "unc2");

    // Replacement in set 5
    set_line(32'h1100); do_fetch(32'h0000_0158, 1'b0, 1'b0, 32'h1102, 4, "t1_miss");
    set_line(32'h2200); do_fetch(32'h0000_0254, 1'b0, 1'b0, 32'h2201, 4, "t2_miss");
    do_fetch(32'h0000_015c, 1'b0, 1'b1, 32'h1103, 0, "t1_hit");
    do_fetch(32'h0000_0250, 1'b0, 1'b1, 32'h2200, 0, "t2_hit");
    set_line(32'h3300); do_fetch(32'h0000_0358, 1'b0, 1'b0, 32'h3302, 4, "t3_miss");
    do_fetch(32'h0000_025c, 1'b0, 1'b1, 32'h2203, 0, "t2_kept");
    set_line(32'h4400); do_fetch(32'h0000_0450, 1'b0, 1'b0, 32'h4400, 4, "t4_miss");
    do_fetch(32'h0000_0354, 1'b0, 1'b1, 32'h3301, 0, "t3_kept");
    do_fetch(32'h0000_0458, 1'b0, 1'b1, 32'h4402, 0, "t4_hit");
    set_line(32'h1100); do_fetch(32'h0000_0150, 1'b0, 1'b0, 32'h1100, 4, "t1_evicted");
    do_fetch(32'h0000_045c, 1'b0, 1'b1, 32'h4403, 0, "t4_kept");

    // Index invalidate wins over a concurrent fetch
    inv_valid = 1'b1; inv_index = 4'h5; valid = 1'b1; addr = 32'h0000_0150;
    #1;
    chk("inv_idx_ok", 32'(inv_ok), 32'd1);
    chk("inv_idx_addr_ok", 32'(addr_ok), 32'd0);
    @(negedge clk_g);
    inv_valid = 1'b0; valid = 1'b0; addr = 32'h0;
    #1;
    chk("inv_idx_ok_drop", 32'(inv_ok), 32'd0);
    @(negedge clk_g);
    set_line(32'h1100); do_fetch(32'h0000_0154, 1'b0, 1'b0, 32'h1101, 4, "inv_idx_miss");
    do_fetch(32'h1fc0_0000, 1'b0, 1'b1, 32'hA0, 0, "set0_kept");

    // Invalidate-all sweep: 16 cycles, fetches ignored while busy
    inv_all = 1'b1;
    #1;
    chk("invall_accept_ok", {30'h0, inv_ok, addr_ok}, 32'h0);
    @(negedge clk_g);
    inv_all = 1'b0; valid = 1'b1; addr = 32'h1fc0_0000;
    hit_k = 0; aok = 0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (addr_ok) aok++;
      if (inv_ok) begin
        hit_k = k;
        valid = 1'b0;
        break;
      end
      @(negedge clk_g);
    end
    valid = 1'b0; addr = 32'h0;
    chk("invall_latency", 32'(hit_k), 32'd16);
    chk("invall_addr_ok", 32'(aok), 32'd0);
    @(negedge clk_g);
    #1;
    chk("invall_ok_once", 32'(inv_ok), 32'd0);
    @(negedge clk_g);
    set_line(32'hA0);   do_fetch(32'h1fc0_0008, 1'b0, 1'b0, 32'hA2, 4, "invall_miss0");
    set_line(32'h4400); do_fetch(32'h0000_0458, 1'b0, 1'b0, 32'h4402, 4, "invall_miss5");

    // Reset during a refill abandons the miss
    set_line(32'h7700);
    valid = 1'b1; addr = 32'h0000_077c;
    @(negedge clk_g);
    valid = 1'b0; addr = 32'h0;
    @(negedge clk_g);
    #1;
    chk("rst_mid_rd_req", 32'(rd_req), 32'd1);
    rd_rdy = 1'b1;
    @(negedge clk_g);
    rd_rdy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      ret_valid = 1'b1; ret_data = beat_mem[b];
      #1;
      chk("rst_mid_early_beat", 32'(data_ok), 32'd0);
      @(negedge clk_g);
    end
    reset = 1'b1; ret_valid = 1'b1; ret_data = beat_mem[2];
    #1;
    chk("rst_mid_beat2", {30'h0, data_ok, rd_req}, 32'h0);
    @(negedge clk_g);
    reset = 1'b0; ret_valid = 1'b1; ret_last = 1'b1; ret_data = beat_mem[3];
    #1;
    chk("rst_mid_beat3", 32'(data_ok), 32'd0);
    @(negedge clk_g);
    ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
    @(negedge clk_g);
    do_fetch(32'h0000_077c, 1'b0, 1'b0, 32'h7703, 4, "rst_refetch");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
